mux_n_to_1_pipe: RTL and testbench

- Parametrised, registered N-to-1 multiplexer. Generalises the 2:1 32-bit combinational datapath mux in width and input count.
- Adds a valid/ready handshake with a 2-entry skid buffer, so it can sit between MIPS pipeline stages (forwarding / writeback select) and absorb a one-cycle downstream stall without combinational ready paths.

---
 rtl/mux_n_to_1_pipe_pkg.sv | 17 +
 rtl/mux_n_to_1_comb.sv | 28 ++
 rtl/mux_n_to_1_pipe.sv | 124 ++++++++++++
 tb/tb_mux_n_to_1_pipe.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mux_n_to_1_pipe_pkg.sv
// Shared pipeline definitions: skid-buffer occupancy encodings, default datapath
// width and the clog2 helper macro used to derive select widths.
`ifndef MIPS_CLOG2
`define MIPS_CLOG2(n) ($clog2(n))
`endif

package mips_pipe_defs;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } occ_state_t;

  localparam int DEFAULT_WIDTH = 32;

endpackage

// File: rtl/mux_n_to_1_comb.sv
// Purely combinational WIDTH x NUM_IN selector; flags an index that names no input
// and returns zero data for it.
module mux_n_to_1_comb
  import mips_pipe_defs::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = `MIPS_CLOG2(NUM_IN)
) (
  input  logic [WIDTH*NUM_IN-1:0] in_bus,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        data,
  output logic                    sel_err
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    data    = '0;
    sel_err = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        data    = in_bus[k*WIDTH +: WIDTH];
        sel_err = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_n_to_1_pipe.sv
// Registered N-to-1 mux with valid/ready handshake and a 2-entry skid buffer.
// Optional build macro MUX_PIPE_HOLD_LAST_EN: Mux_Out holds the last delivered value when idle.
module mux_n_to_1_pipe
  import mips_pipe_defs::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = `MIPS_CLOG2(NUM_IN)  // derived; leave at default
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [WIDTH*NUM_IN-1:0] In_Bus,
  input  logic [SEL_W-1:0]        Sel,
  input  logic                    In_Valid,
  output logic                    In_Ready,
  input  logic                    Flush,
  output logic [WIDTH-1:0]        Mux_Out,
  output logic                    Out_Valid,
  input  logic                    Out_Ready,
  output logic                    Sel_Err
);

`ifdef MUX_PIPE_HOLD_LAST_EN
  localparam bit HOLD_LAST = 1'b1;
`else
  localparam bit HOLD_LAST = 1'b0;
`endif

  occ_state_t       state;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             sel_err_q;

  logic [WIDTH-1:0] pick_data;
  logic             pick_err;
  logic             accept;
  logic             deliver;

  mux_n_to_1_comb #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_sel (
    .in_bus  (In_Bus),
    .sel     (Sel),
    .data    (pick_data),
    .sel_err (pick_err)
  );

  assign accept  = In_Valid && in_ready_q;
  assign deliver = out_valid_q && Out_Ready;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state       <= ST_EMPTY;
      main_q      <= '0;
      // NOTE: the skid register is cleared on reset as well, so no stale entry can ever surface.
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      sel_err_q   <= 1'b0;
    end else if (Flush) begin
      // Flush outranks accept and deliver; a same-cycle input is dropped.
      state       <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      sel_err_q   <= 1'b0;
    end else begin
      sel_err_q <= accept && pick_err;
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            state       <= ST_ONE;
            main_q      <= pick_data;
            out_valid_q <= 1'b1;
          end
        end
        ST_ONE: begin
          case ({accept, deliver})
            2'b10: begin
              state      <= ST_TWO;
              skid_q     <= pick_data;
              in_ready_q <= 1'b0;
            end
            2'b01: begin
              state       <= ST_EMPTY;
              out_valid_q <= 1'b0;
              if (!HOLD_LAST) main_q <= '0;
            end
            2'b11:   main_q <= pick_data;
            default: ;
          endcase
        end
        ST_TWO: begin
          // In_Ready is low here, so only a delivery can move the state.
          if (deliver) begin
            state      <= ST_ONE;
            main_q     <= skid_q;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state       <= ST_EMPTY;
          main_q      <= '0;
          skid_q      <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign In_Ready  = in_ready_q;
  assign Out_Valid = out_valid_q;
  assign Mux_Out   = main_q;
  assign Sel_Err   = sel_err_q;

endmodule

// File: tb/tb_mux_n_to_1_pipe.sv
// Bench for mux_n_to_1_pipe: a NUM_IN=4 and a NUM_IN=3 instance checked against a
// queue-based scoreboard with an occupancy model; honours MUX_PIPE_HOLD_LAST_EN.
module tb_mux_n_to_1_pipe;

`ifdef MUX_PIPE_HOLD_LAST_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [127:0]     bus;
  logic [1:0]       in_valid, flush, out_ready;
  logic [1:0][1:0]  sel;
  logic [1:0]       in_ready, out_valid, sel_err;
  logic [1:0][31:0] mux_out;

  always #5 clk = ~clk;

  mux_n_to_1_pipe #(.WIDTH(32), .NUM_IN(4)) dut4 (
    .Clk(clk), .Reset(rst), .In_Bus(bus), .Sel(sel[0]), .In_Valid(in_valid[0]),
    .In_Ready(in_ready[0]), .Flush(flush[0]), .Mux_Out(mux_out[0]),
    .Out_Valid(out_valid[0]), .Out_Ready(out_ready[0]), .Sel_Err(sel_err[0])
  );

  mux_n_to_1_pipe #(.WIDTH(32), .NUM_IN(3)) dut3 (
    .Clk(clk), .Reset(rst), .In_Bus(bus[95:0]), .Sel(sel[1]), .In_Valid(in_valid[1]),
    .In_Ready(in_ready[1]), .Flush(flush[1]), .Mux_Out(mux_out[1]),
    .Out_Valid(out_valid[1]), .Out_Ready(out_ready[1]), .Sel_Err(sel_err[1])
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] sb0[$];
  logic [31:0] sb1[$];
  logic [31:0] idle_val[2];
  logic        err_pend[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int q_size(input int i);
    return (i == 0) ? sb0.size() : sb1.size();
  endfunction

  function automatic logic [31:0] q_front(input int i);
    if (q_size(i) == 0) return 32'h0;
    return (i == 0) ? sb0[0] : sb1[0];
  endfunction

  task automatic q_pop(input int i);
    if (i == 0) void'(sb0.pop_front());
    else        void'(sb1.pop_front());
  endtask

  task automatic q_push(input int i, input logic [31:0] v);
    if (i == 0) sb0.push_back(v);
    else        sb1.push_back(v);
  endtask

  task automatic model_clear();
    sb0.delete();
    sb1.delete();
    for (int i = 0; i < 2; i++) begin
      idle_val[i] = 32'h0;
      err_pend[i] = 1'b0;
    end
  endtask

  // Compare one instance against the model, then advance the model across the coming edge.
  task automatic model_step(input int i);
    int          n;
    int          num;
    int          s;
    logic        acc;
    logic        del;
    logic [31:0] d;
    n   = q_size(i);
    num = (i == 0) ? 4 : 3;
    s   = int'(sel[i]);
    check($sformatf("d%0d out_valid", i), 32'(out_valid[i]), 32'(n > 0));
    check($sformatf("d%0d in_ready", i),  32'(in_ready[i]),  32'(n < 2));
    check($sformatf("d%0d mux_out", i),   mux_out[i], (n > 0) ? q_front(i) : idle_val[i]);
    check($sformatf("d%0d sel_err", i),   32'(sel_err[i]), 32'(err_pend[i]));
    if (flush[i]) begin
      if (i == 0) sb0.delete();
      else        sb1.delete();
      idle_val[i] = 32'h0;
      err_pend[i] = 1'b0;
    end else begin
      del = (n > 0) && out_ready[i];
      acc = in_valid[i] && (n < 2);
      if (del) begin
        idle_val[i] = HOLD ? q_front(i) : 32'h0;
        q_pop(i);
      end
      if (acc) begin
        d = (s < num) ? bus[s*32 +: 32] : 32'h0;
        q_push(i, d);
      end
      err_pend[i] = acc && (s >= num);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic v, input logic [1:0] s,
                       input logic f, input logic r);
    in_valid[i]  = v;
    sel[i]       = s;
    flush[i]     = f;
    out_ready[i] = r;
  endtask

  task automatic reset_checks(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s d%0d out_valid", tag, i), 32'(out_valid[i]), 32'h0);
      check($sformatf("%s d%0d mux_out", tag, i),   mux_out[i],        32'h0);
      check($sformatf("%s d%0d in_ready", tag, i),  32'(in_ready[i]),  32'h1);
      check($sformatf("%s d%0d sel_err", tag, i),   32'(sel_err[i]),   32'h0);
    end
  endtask

  // Assert reset between clock edges and check the outputs clear before the next edge.
  task automatic reset_mid();
    #2 rst = 1'b1;
    #1 reset_checks("async_reset");
    model_clear();
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus = {32'h0000_DDDD, 32'h0000_CCCC, 32'h0000_BBBB, 32'h0000_AAAA};
    drive(0, 1'b0, 2'd0, 1'b0, 1'b1);
    drive(1, 1'b0, 2'd0, 1'b0, 1'b1);
    model_clear();
    #1 reset_checks("reset");
    #11 rst = 1'b0;
    @(posedge clk);
    #1;

    // Single accept of input 2, then drain.
    drive(0, 1'b1, 2'd2, 1'b0, 1'b1);
    tick();
    drive(0, 1'b0, 2'd0, 1'b0, 1'b1);
    tick();
    tick();

    // Back-to-back Sel 0..3 at full throughput.
    for (int s = 0; s < 4; s++) begin
      drive(0, 1'b1, 2'(s), 1'b0, 1'b1);
      tick();
    end
    drive(0, 1'b0, 2'd0, 1'b0, 1'b1);
    tick();
    tick();

    // Downstream stall fills the skid buffer, then releases.
    drive(0, 1'b1, 2'd0, 1'b0, 1'b0);
    tick();
    drive(0, 1'b1, 2'd1, 1'b0, 1'b0);
    tick();
    drive(0, 1'b1, 2'd3, 1'b0, 1'b0);  // ignored while In_Ready=0
    tick();
    drive(0, 1'b0, 2'd0, 1'b0, 1'b1);
    tick();
    tick();
    tick();

    // Out-of-range select on the 3-input instance, then a legal one.
    drive(1, 1'b1, 2'd3, 1'b0, 1'b1);
    tick();
    drive(1, 1'b1, 2'd2, 1'b0, 1'b1);
    tick();
    drive(1, 1'b0, 2'd0, 1'b0, 1'b1);
    tick();
    tick();

    // Flush in TWO with a concurrent input on both instances.
    drive(0, 1'b1, 2'd0, 1'b0, 1'b0);
    drive(1, 1'b1, 2'd0, 1'b0, 1'b0);
    tick();
    drive(0, 1'b1, 2'd2, 1'b0, 1'b0);
    drive(1, 1'b1, 2'd1, 1'b0, 1'b0);
    tick();
    drive(0, 1'b1, 2'd1, 1'b1, 1'b0);
    drive(1, 1'b1, 2'd3, 1'b1, 1'b0);
    tick();
    drive(0, 1'b0, 2'd0, 1'b0, 1'b1);
    drive(1, 1'b0, 2'd0, 1'b0, 1'b1);
    tick();
    tick();

    // Mixed traffic on both instances.
    for (int c = 0; c < 80; c++) begin
      for (int i = 0; i < 2; i++)
        drive(i, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 3) != 0));
      tick();
    end
    drive(0, 1'b0, 2'd0, 1'b0, 1'b1);
    drive(1, 1'b0, 2'd0, 1'b0, 1'b1);
    tick();
    tick();
    tick();

    // Asynchronous reset while dut4 holds two entries.
    drive(0, 1'b1, 2'd0, 1'b0, 1'b0);
    tick();
    drive(0, 1'b1, 2'd1, 1'b0, 1'b0);
    tick();
    drive(0, 1'b0, 2'd0, 1'b0, 1'b0);
    tick();
    reset_mid();
    drive(0, 1'b0, 2'd0, 1'b0, 1'b1);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
